// File: rtl/dmem_arb_pkg.sv
// Shared types for the MEM-stage data memory port arbiter.
package dmem_arb_pkg;

  localparam int LANES = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    V_RUN  = 3'd1,
    V_TAIL = 3'd2,
    S_CAP  = 3'd3,
    DONE   = 3'd4
  } arb_state_t;

  typedef logic [DW-1:0] lane_data_t [0:LANES-1];

endpackage

// File: rtl/dmem_port_arbiter.sv
// Serialises scalar and 4-lane vector MEM-stage accesses onto one single-port,
// sync-read data memory, stalling the pipeline until the access sequence completes.
module dmem_port_arbiter #(
  parameter int LANES = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ScalarReqM,
  input  logic          MemWriteM,
  input  logic [AW-1:0] DataAdrM,
  input  logic [DW-1:0] WriteDataM,
  input  logic          VecReqM,
  input  logic          MemWriteVecM,
  input  logic [AW-1:0] DataAdrVecM   [0:LANES-1],
  input  logic [DW-1:0] WriteDataMVec [0:LANES-1],
  output logic          StallM,
  output logic [DW-1:0] ReadDataM,
  output logic [DW-1:0] ReadDataVecM  [0:LANES-1],
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  import dmem_arb_pkg::*;

  localparam int              LCW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LCW-1:0]  LANE_ONE  = LCW'(1);
  localparam logic [LCW-1:0]  LAST_LANE = LCW'(LANES - 1);

  arb_state_t     state_q, state_d;
  logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [DW-1:0]  rdata_vec_q [0:LANES-1];
  logic [DW-1:0]  rdata_vec_d [0:LANES-1];

  // Next state, lane counter and read-capture values.
  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    rdata_d     = rdata_q;
    rdata_vec_d = rdata_vec_q;
    case (state_q)
      IDLE: begin
        if (VecReqM) begin
          state_d    = V_RUN;
          lane_cnt_d = LANE_ONE;
        end else if (ScalarReqM) begin
          state_d    = S_CAP;
        end else begin
          state_d    = IDLE;
        end
      end
      V_RUN: begin
        // mem_rdata here belongs to the lane issued one cycle earlier.
        if (!MemWriteVecM) begin
          rdata_vec_d[lane_cnt_q - LANE_ONE] = mem_rdata;
        end else begin
          rdata_vec_d = rdata_vec_q;
        end
        if (lane_cnt_q == LAST_LANE) begin
          state_d    = V_TAIL;
        end else begin
          lane_cnt_d = lane_cnt_q + LANE_ONE;
        end
      end
      V_TAIL: begin
        if (!MemWriteVecM) begin
          rdata_vec_d[LANES-1] = mem_rdata;
        end else begin
          rdata_vec_d = rdata_vec_q;
        end
        lane_cnt_d = '0;
        if (ScalarReqM) begin
          state_d = S_CAP;
        end else begin
          state_d = DONE;
        end
      end
      S_CAP: begin
        if (!MemWriteM) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = rdata_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        lane_cnt_d = '0;
      end
    endcase
  end

  // FSM and read-capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        rdata_vec_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      rdata_q     <= rdata_d;
      rdata_vec_q <= rdata_vec_d;
    end
  end

  assign ReadDataM    = rdata_q;
  assign ReadDataVecM = rdata_vec_q;

  // Memory port mux and stall; everything is quiet while reset is held.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    StallM    = 1'b0;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      StallM    = 1'b0;
    end else begin
      StallM = (ScalarReqM | VecReqM) & (state_q != DONE);
      case (state_q)
        IDLE: begin
          if (VecReqM) begin
            mem_addr  = DataAdrVecM[0];
            mem_wdata = WriteDataMVec[0];
            mem_we    = MemWriteVecM;
          end else if (ScalarReqM) begin
            mem_addr  = DataAdrM;
            mem_wdata = WriteDataM;
            mem_we    = MemWriteM;
          end else begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
          end
        end
        V_RUN: begin
          mem_addr  = DataAdrVecM[lane_cnt_q];
          mem_wdata = WriteDataMVec[lane_cnt_q];
          mem_we    = MemWriteVecM;
        end
        V_TAIL: begin
          // A scalar access sharing the instruction goes out right after the last lane.
          if (ScalarReqM) begin
            mem_addr  = DataAdrM;
            mem_wdata = WriteDataM;
            mem_we    = MemWriteM;
          end else begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
          end
        end
        default: begin
          mem_addr  = '0;
          mem_wdata = '0;
          mem_we    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a sync-read single-port memory model.
module tb_dmem_port_arbiter;

  import dmem_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic        ScalarReqM, MemWriteM, VecReqM, MemWriteVecM;
  logic [31:0] DataAdrM, WriteDataM;
  logic [31:0] DataAdrVecM   [0:3];
  logic [31:0] WriteDataMVec [0:3];
  logic        StallM;
  logic [31:0] ReadDataM;
  logic [31:0] ReadDataVecM  [0:3];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;

  int n_cmp;
  int n_err;

  dmem_port_arbiter #(.LANES(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .ScalarReqM(ScalarReqM), .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
    .VecReqM(VecReqM), .MemWriteVecM(MemWriteVecM), .DataAdrVecM(DataAdrVecM), .WriteDataMVec(WriteDataMVec),
    .StallM(StallM), .ReadDataM(ReadDataM), .ReadDataVecM(ReadDataVecM),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port sync-read memory with a backdoor preload path.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input lane_data_t exp);
    for (int i = 0; i < 4; i++) chk($sformatf("%s%0d", tag, i), ReadDataVecM[i], exp[i]);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    tick();
  endtask

  task automatic clear_inputs;
    ScalarReqM = 1'b0; MemWriteM = 1'b0; DataAdrM = 32'h0; WriteDataM = 32'h0;
    VecReqM = 1'b0; MemWriteVecM = 1'b0;
    DataAdrVecM   = '{32'h0, 32'h0, 32'h0, 32'h0};
    WriteDataMVec = '{32'h0, 32'h0, 32'h0, 32'h0};
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    bd_we = 1'b1; bd_addr = 6'd0; bd_data = 32'h0;
    load(6'd16, 32'hDEADBEEF);   // 0x40
    load(6'd17, 32'h12345678);   // 0x44
    load(6'd4, 32'd1); load(6'd5, 32'd2); load(6'd6, 32'd3); load(6'd7, 32'd4);
    bd_we = 1'b0;

    // Reset state with no requests
    chk1("rst_stall", StallM, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rd", ReadDataM, 32'h0);
    chk_vec("rst_vec", '{32'h0, 32'h0, 32'h0, 32'h0});
    reset = 1'b0;
    tick();

    // Scalar load from 0x40
    ScalarReqM = 1'b1; MemWriteM = 1'b0; DataAdrM = 32'h40;
    #1;
    chk1("s_stall0", StallM, 1'b1);
    chk("s_addr", mem_addr, 32'h40);
    chk1("s_we", mem_we, 1'b0);
    tick();
    chk1("s_stall1", StallM, 1'b1);
    tick();
    chk1("s_done_stall", StallM, 1'b0);
    chk("s_done_addr", mem_addr, 32'h0);
    chk("s_rd", ReadDataM, 32'hDEADBEEF);
    ScalarReqM = 1'b0;
    tick();
    chk1("idle_stall", StallM, 1'b0);
    chk1("idle_we", mem_we, 1'b0);
    chk("idle_addr", mem_addr, 32'h0);

    // Vector load 0x10..0x1C
    VecReqM = 1'b1; MemWriteVecM = 1'b0;
    DataAdrVecM = '{32'h10, 32'h14, 32'h18, 32'h1C};
    #1;
    for (int c = 0; c < 5; c++) begin
      chk1($sformatf("vl_stall%0d", c), StallM, 1'b1);
      chk1($sformatf("vl_we%0d", c), mem_we, 1'b0);
      if (c < 4) chk($sformatf("vl_addr%0d", c), mem_addr, 32'h10 + 32'(4 * c));
      else chk("vl_tail_addr", mem_addr, 32'h0);
      tick();
    end
    chk1("vl_done_stall", StallM, 1'b0);
    chk_vec("vl_vec", '{32'd1, 32'd2, 32'd3, 32'd4});
    VecReqM = 1'b0;
    tick();

    // Vector store, all lanes aliased to 0x20
    VecReqM = 1'b1; MemWriteVecM = 1'b1;
    DataAdrVecM   = '{32'h20, 32'h20, 32'h20, 32'h20};
    WriteDataMVec = '{32'd5, 32'd6, 32'd7, 32'd8};
    #1;
    for (int c = 0; c < 4; c++) begin
      chk1($sformatf("vs_we%0d", c), mem_we, 1'b1);
      chk($sformatf("vs_addr%0d", c), mem_addr, 32'h20);
      chk($sformatf("vs_wdata%0d", c), mem_wdata, 32'd5 + 32'(c));
      chk1($sformatf("vs_stall%0d", c), StallM, 1'b1);
      tick();
    end
    chk1("vs_tail_we", mem_we, 1'b0);
    chk1("vs_tail_stall", StallM, 1'b1);
    tick();
    chk1("vs_done_stall", StallM, 1'b0);
    chk_vec("vs_vec", '{32'd1, 32'd2, 32'd3, 32'd4});
    VecReqM = 1'b0; MemWriteVecM = 1'b0;
    tick();
    chk("vs_mem20", mem[8], 32'd8);

    // Vector load (reversed) plus scalar store of 0xAA to 0x30
    VecReqM = 1'b1; MemWriteVecM = 1'b0;
    DataAdrVecM = '{32'h1C, 32'h18, 32'h14, 32'h10};
    ScalarReqM = 1'b1; MemWriteM = 1'b1; DataAdrM = 32'h30; WriteDataM = 32'hAA;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk1($sformatf("b_stall%0d", c), StallM, 1'b1);
      chk1($sformatf("b_we%0d", c), mem_we, 1'b0);
      chk($sformatf("b_addr%0d", c), mem_addr, 32'h1C - 32'(4 * c));
      tick();
    end
    chk1("b_tail_stall", StallM, 1'b1);
    chk("b_tail_addr", mem_addr, 32'h30);
    chk1("b_tail_we", mem_we, 1'b1);
    chk("b_tail_wdata", mem_wdata, 32'hAA);
    tick();
    chk1("b_scap_stall", StallM, 1'b1);
    chk1("b_scap_we", mem_we, 1'b0);
    tick();
    chk1("b_done_stall", StallM, 1'b0);
    chk_vec("b_vec", '{32'd4, 32'd3, 32'd2, 32'd1});
    chk("b_rd_kept", ReadDataM, 32'hDEADBEEF);
    clear_inputs();
    tick();
    chk("b_mem30", mem[12], 32'hAA);

    // Back-to-back scalar loads: 0x44 then 0x40
    ScalarReqM = 1'b1; MemWriteM = 1'b0; DataAdrM = 32'h44;
    #1;
    chk("bb_addr0", mem_addr, 32'h44);
    tick();
    tick();
    chk1("bb_done0_stall", StallM, 1'b0);
    chk("bb_done0_addr", mem_addr, 32'h0);
    chk("bb_rd0", ReadDataM, 32'h12345678);
    DataAdrM = 32'h40;
    tick();
    chk1("bb_idle_stall", StallM, 1'b1);
    chk("bb_addr1", mem_addr, 32'h40);
    tick();
    chk1("bb_scap_stall", StallM, 1'b1);
    tick();
    chk1("bb_done1_stall", StallM, 1'b0);
    chk("bb_rd1", ReadDataM, 32'hDEADBEEF);
    ScalarReqM = 1'b0;
    tick();

    // Reset in the middle of a vector run (lane_cnt=2)
    VecReqM = 1'b1; MemWriteVecM = 1'b0;
    DataAdrVecM = '{32'h10, 32'h14, 32'h18, 32'h1C};
    ScalarReqM = 1'b1; MemWriteM = 1'b0; DataAdrM = 32'h44;
    tick();
    tick();
    chk("mr_lane2_addr", mem_addr, 32'h18);
    reset = 1'b1;
    #1;
    chk1("mr_stall", StallM, 1'b0);
    chk1("mr_we", mem_we, 1'b0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_rd", ReadDataM, 32'h0);
    chk_vec("mr_vec", '{32'h0, 32'h0, 32'h0, 32'h0});
    tick();
    reset = 1'b0;
    #1;
    chk1("mr_restart_stall", StallM, 1'b1);
    chk("mr_restart_addr", mem_addr, 32'h10);
    tick();
    chk("mr_lane1_addr", mem_addr, 32'h14);
    tick(); tick(); tick();
    chk("mr_tail_addr", mem_addr, 32'h44);
    tick(); tick();
    chk1("mr_done_stall", StallM, 1'b0);
    chk("mr_done_rd", ReadDataM, 32'h12345678);
    chk_vec("mr_done_vec", '{32'd1, 32'd2, 32'd3, 32'd4});
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
